// File: rtl/ctrl_fsm_param_if.sv
// ============================================================================
// Module   : ctrl_fsm_param_if
// Brief    : Controller <-> pipeline signal bundle for ctrl_fsm_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctrl_fsm_param_if #(
    parameter int N_EXC  = 4,
    parameter int PERF_W = 16
);
    localparam int CAUSE_W = (N_EXC > 1) ? $clog2(N_EXC) : 1;

    logic               fetch_enable_i;
    logic               ctrl_busy_o;
    logic               is_decoding_o;
    logic               illegal_insn_i;
    logic               eret_insn_i;
    logic               pipe_flush_i;
    logic               jump_i;
    logic               branch_taken_ex_i;
    logic               instr_valid_i;
    logic               id_ready_i;
    logic               ex_valid_i;
    logic               jr_stall_i;
    logic               load_stall_i;
    logic               instr_req_o;
    logic               pc_set_o;
    logic [2:0]         pc_mux_o;
    logic [N_EXC-1:0]   exc_req_i;
    logic [N_EXC-1:0]   exc_ack_o;
    logic [CAUSE_W-1:0] exc_cause_o;
    logic               exc_save_if_o;
    logic               exc_save_id_o;
    logic               exc_restore_id_o;
    logic               halt_if_o;
    logic               halt_id_o;
    logic               dbg_req_i;
    logic               dbg_resume_i;
    logic               dbg_halted_o;
    logic               perf_clr_i;
    logic [PERF_W-1:0]  perf_jump_cnt_o;
    logic [PERF_W-1:0]  perf_jr_cnt_o;
    logic [PERF_W-1:0]  perf_ld_cnt_o;
    logic               err_b2b_branch_o;

    modport master (
        input  fetch_enable_i, illegal_insn_i, eret_insn_i, pipe_flush_i, jump_i,
               branch_taken_ex_i, instr_valid_i, id_ready_i, ex_valid_i,
               jr_stall_i, load_stall_i, exc_req_i, dbg_req_i, dbg_resume_i,
               perf_clr_i,
        output ctrl_busy_o, is_decoding_o, instr_req_o, pc_set_o, pc_mux_o,
               exc_ack_o, exc_cause_o, exc_save_if_o, exc_save_id_o,
               exc_restore_id_o, halt_if_o, halt_id_o, dbg_halted_o,
               perf_jump_cnt_o, perf_jr_cnt_o, perf_ld_cnt_o, err_b2b_branch_o
    );

    modport slave (
        output fetch_enable_i, illegal_insn_i, eret_insn_i, pipe_flush_i, jump_i,
               branch_taken_ex_i, instr_valid_i, id_ready_i, ex_valid_i,
               jr_stall_i, load_stall_i, exc_req_i, dbg_req_i, dbg_resume_i,
               perf_clr_i,
        input  ctrl_busy_o, is_decoding_o, instr_req_o, pc_set_o, pc_mux_o,
               exc_ack_o, exc_cause_o, exc_save_if_o, exc_save_id_o,
               exc_restore_id_o, halt_if_o, halt_id_o, dbg_halted_o,
               perf_jump_cnt_o, perf_jr_cnt_o, perf_ld_cnt_o, err_b2b_branch_o
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_fsm_param.sv
// ============================================================================
// Module   : ctrl_fsm_param
// Brief    : Parametrised core controller FSM with drain, exceptions, debug, perf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_fsm_param #(
    parameter int FLUSH_STAGES = 2,
    parameter int N_EXC        = 4,
    parameter int PERF_W       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ctrl_fsm_param_if.master  bus
);
    localparam int CAUSE_W = (N_EXC > 1) ? $clog2(N_EXC) : 1;
    // Wide enough to hold FLUSH_STAGES itself, so 8 does not alias to 0.
    localparam int CNT_W   = $clog2(FLUSH_STAGES + 1);
    localparam logic [CNT_W-1:0] c_FLUSH_LOAD = CNT_W'(FLUSH_STAGES);

    localparam logic [2:0] c_PC_BOOT   = 3'd0;
    localparam logic [2:0] c_PC_JUMP   = 3'd1;
    localparam logic [2:0] c_PC_BRANCH = 3'd2;
    localparam logic [2:0] c_PC_EXC    = 3'd3;
    localparam logic [2:0] c_PC_ERET   = 3'd4;

    typedef enum logic [2:0] {
        S_RESET       = 3'd0,
        S_BOOT_SET    = 3'd1,
        S_FIRST_FETCH = 3'd2,
        S_DECODE      = 3'd3,
        S_FLUSH       = 3'd4,
        S_SLEEP       = 3'd5,
        S_DBG_HALT    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbg_pend_q, dbg_pend_d;
    logic               jump_done_q, jump_done_d;
    logic               branch_q;
    logic               err_q;

    logic               w_exc_any;
    logic [CAUSE_W-1:0] w_grant_idx;
    logic [N_EXC-1:0]   w_grant_oh;
    logic               w_jump_set;
    logic               w_instr_req, w_busy, w_pc_set, w_decoding;
    logic [2:0]         w_pc_mux;
    logic [N_EXC-1:0]   w_ack;
    logic [CAUSE_W-1:0] w_cause;
    logic               w_save_if, w_save_id, w_restore_id;
    logic               w_halt_if, w_halt_id, w_dbg_halted;
    logic               w_unused_illegal;

    assign w_unused_illegal = bus.illegal_insn_i;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_grant_idx = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (bus.exc_req_i[i]) begin
                w_grant_idx = CAUSE_W'(i);
            end
        end
        w_exc_any  = |bus.exc_req_i;
        w_grant_oh = w_exc_any ? (N_EXC'(1) << w_grant_idx) : '0;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dbg_pend_d   = dbg_pend_q;
        w_instr_req  = 1'b1;
        w_busy       = 1'b1;
        w_pc_set     = 1'b0;
        w_pc_mux     = c_PC_BOOT;
        w_ack        = '0;
        w_cause      = '0;
        w_save_if    = 1'b0;
        w_save_id    = 1'b0;
        w_restore_id = 1'b0;
        w_halt_if    = 1'b0;
        w_halt_id    = 1'b0;
        w_decoding   = 1'b0;
        w_dbg_halted = 1'b0;
        w_jump_set   = 1'b0;

        case (state_q)
            S_RESET: begin
                w_instr_req = 1'b0;
                w_busy      = 1'b0;
                if (bus.fetch_enable_i) state_d = S_BOOT_SET;
            end
            S_BOOT_SET: begin
                w_pc_set = 1'b1;
                w_pc_mux = c_PC_BOOT;
                state_d  = S_FIRST_FETCH;
            end
            S_FIRST_FETCH: begin
                if (bus.id_ready_i) state_d = S_DECODE;
                if (w_exc_any) begin
                    w_pc_set  = 1'b1;
                    w_pc_mux  = c_PC_EXC;
                    w_ack     = w_grant_oh;
                    w_cause   = w_grant_idx;
                    w_save_if = 1'b1;
                end
            end
            S_DECODE: begin
                cnt_d = c_FLUSH_LOAD;
                // A taken branch in EX squashes whatever ID holds this cycle.
                if (bus.branch_taken_ex_i) begin
                    w_pc_set = 1'b1;
                    w_pc_mux = c_PC_BRANCH;
                end else if (bus.instr_valid_i) begin
                    w_decoding = 1'b1;
                    if (bus.jump_i) begin
                        w_pc_mux   = c_PC_JUMP;
                        w_jump_set = !bus.jr_stall_i && !jump_done_q;
                        w_pc_set   = w_jump_set;
                    end else if (bus.eret_insn_i) begin
                        w_pc_mux     = c_PC_ERET;
                        w_restore_id = 1'b1;
                        w_jump_set   = !jump_done_q;
                        w_pc_set     = w_jump_set;
                        if (!bus.fetch_enable_i) begin
                            w_halt_if = 1'b1;
                            w_halt_id = 1'b1;
                            state_d   = S_FLUSH;
                        end
                    end else if (bus.dbg_req_i) begin
                        w_halt_if  = 1'b1;
                        w_halt_id  = 1'b1;
                        dbg_pend_d = 1'b1;
                        state_d    = S_FLUSH;
                    end else if (w_exc_any) begin
                        w_pc_set  = 1'b1;
                        w_pc_mux  = c_PC_EXC;
                        w_ack     = w_grant_oh;
                        w_cause   = w_grant_idx;
                        w_halt_id = 1'b1;
                        w_save_id = 1'b1;
                    end else if (bus.pipe_flush_i) begin
                        w_halt_if = 1'b1;
                        w_halt_id = 1'b1;
                        state_d   = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_halt_if = 1'b1;
                w_halt_id = 1'b1;
                if (cnt_q == '0) begin
                    if (dbg_pend_q) begin
                        dbg_pend_d = 1'b0;
                        state_d    = S_DBG_HALT;
                    end else if (bus.fetch_enable_i) begin
                        w_halt_if = 1'b0;
                        state_d   = S_DECODE;
                    end else begin
                        state_d = S_SLEEP;
                    end
                end else if (bus.ex_valid_i) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SLEEP: begin
                w_instr_req = 1'b0;
                w_busy      = 1'b0;
                w_halt_if   = 1'b1;
                w_halt_id   = 1'b1;
                if (bus.fetch_enable_i || w_exc_any) state_d = S_FIRST_FETCH;
            end
            S_DBG_HALT: begin
                w_instr_req  = 1'b0;
                w_busy       = 1'b0;
                w_halt_if    = 1'b1;
                w_halt_id    = 1'b1;
                w_dbg_halted = 1'b1;
                if (bus.dbg_resume_i) state_d = S_FIRST_FETCH;
            end
            default: state_d = S_RESET;
        endcase

        jump_done_d = (w_jump_set || jump_done_q) && !bus.id_ready_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            dbg_pend_q  <= 1'b0;
            jump_done_q <= 1'b0;
            branch_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_pend_q  <= dbg_pend_d;
            jump_done_q <= jump_done_d;
            branch_q    <= bus.branch_taken_ex_i;
            err_q       <= err_q || (bus.branch_taken_ex_i && branch_q);
        end
    end

    logic [2:0] w_perf_evt;
    assign w_perf_evt = {bus.load_stall_i, bus.jr_stall_i,
                         bus.jump_i && bus.instr_valid_i};

    for (genvar g = 0; g < 3; g++) begin : g_perf
        logic [PERF_W-1:0] perf_q;
        always_ff @(posedge clk) begin
            if (rst || bus.perf_clr_i) begin
                perf_q <= '0;
            end else if (w_perf_evt[g] && (perf_q != '1)) begin
                perf_q <= perf_q + PERF_W'(1);
            end
        end
    end

    assign bus.ctrl_busy_o      = w_busy;
    assign bus.is_decoding_o    = w_decoding;
    assign bus.instr_req_o      = w_instr_req;
    assign bus.pc_set_o         = w_pc_set;
    assign bus.pc_mux_o         = w_pc_mux;
    assign bus.exc_ack_o        = w_ack;
    assign bus.exc_cause_o      = w_cause;
    assign bus.exc_save_if_o    = w_save_if;
    assign bus.exc_save_id_o    = w_save_id;
    assign bus.exc_restore_id_o = w_restore_id;
    assign bus.halt_if_o        = w_halt_if;
    assign bus.halt_id_o        = w_halt_id;
    assign bus.dbg_halted_o     = w_dbg_halted;
    assign bus.perf_jump_cnt_o  = g_perf[0].perf_q;
    assign bus.perf_jr_cnt_o    = g_perf[1].perf_q;
    assign bus.perf_ld_cnt_o    = g_perf[2].perf_q;
    assign bus.err_b2b_branch_o = err_q;

endmodule

`default_nettype wire
